// File: rtl/wb_job_scheduler.sv
// wb_job_scheduler: Wishbone-fronted job queue. Software pushes job words
// into a command FIFO. An IDLE/ISSUE/WAIT FSM offers each job to the
// datapath and then waits for its one-cycle result strobe. The result is
// captured into a readable RESULT register.
// Optional feature: define WB_JOB_SCHEDULER_IRQ_EN to get a level interrupt
// (irq_en & res_valid). Without it, irq_o is tied low and CTRL bit1 is
// read-as-zero.
module wb_job_scheduler #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        job_valid_o,
  output logic [31:0] job_data_o,
  input  logic        job_ready_i,
  input  logic        res_valid_i,
  input  logic [31:0] res_data_i,
  output logic        busy_o,
  output logic        irq_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] REG_CMD    = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_RESULT = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            ack_q;
  logic [31:0]     dat_q, rd_data;
  logic            enable_q, enable_d;
  logic            irq_en_q, irq_en_d;
  logic            ovf_q, ovf_d;
  logic            res_valid_q, res_valid_d;
  logic [31:0]     result_q, result_d;

  logic        sel, acc, wr, rd, full, empty, push, pop, capture, ovf_set;
  logic [1:0]  idx;
  logic [7:0]  cnt8;

  // A new access is accepted only when no ack is in flight, so every ack is
  // followed by at least one low cycle even if the master keeps stb high.
  assign sel     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign acc     = sel & ~ack_q;
  assign wr      = acc & wbs_we_i;
  assign rd      = acc & ~wbs_we_i;
  assign idx     = wbs_adr_i[3:2];
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  // Fullness is the pre-edge value, so a push into a full FIFO is dropped even
  // when the FSM pops on the same edge.
  assign push    = wr & (idx == REG_CMD) & ~full;
  assign ovf_set = wr & (idx == REG_CMD) & full;
  assign pop     = (state_q == S_ISSUE) & job_ready_i;
  assign capture = (state_q == S_WAIT) & res_valid_i;
  assign cnt8    = 8'(count_q);

  logic unused_inputs;
  assign unused_inputs = ^{wbs_sel_i, wbs_adr_i[1:0], cnt8[7:4]};

  // Register read mux, sampled into dat_q on the accepting edge.
  always_comb begin
    rd_data = '0;
    case (idx)
      REG_STATUS: rd_data = {24'b0, cnt8[3:0], full, empty, res_valid_q, ovf_q};
      REG_RESULT: rd_data = result_q;
      REG_CTRL:   rd_data = {30'b0, irq_en_q, enable_q};
      default:    rd_data = '0;
    endcase
  end

  // Control/status next state. A capture wins over a RESULT read-clear; the
  // read still returns the old value because rd_data uses pre-edge state.
  always_comb begin
    enable_d    = enable_q;
    irq_en_d    = irq_en_q;
    ovf_d       = ovf_q;
    res_valid_d = res_valid_q;
    result_d    = result_q;
    if (wr && idx == REG_CTRL) begin
      enable_d = wbs_dat_i[0];
`ifdef WB_JOB_SCHEDULER_IRQ_EN
      irq_en_d = wbs_dat_i[1];
`endif
      if (wbs_dat_i[31]) ovf_d = 1'b0;
    end
    if (ovf_set) ovf_d = 1'b1;
    if (capture) begin
      result_d    = res_data_i;
      res_valid_d = 1'b1;
    end else if (rd && idx == REG_RESULT) begin
      res_valid_d = 1'b0;
    end
  end

  // Job FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable_q && !empty) state_d = S_ISSUE;
      S_ISSUE: if (job_ready_i)        state_d = S_WAIT;
      S_WAIT:  if (res_valid_i)        state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  // FIFO occupancy next state.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wbs_dat_i;
  end

  // State registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      enable_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      ack_q       <= acc;
      dat_q       <= rd ? rd_data : 32'h0;
      enable_q    <= enable_d;
      irq_en_q    <= irq_en_d;
      ovf_q       <= ovf_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
    end
  end

`ifdef WB_JOB_SCHEDULER_IRQ_EN
  logic irq_q;
  // Interrupt register follows irq_en & res_valid exactly (built from next state).
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) irq_q <= 1'b0;
    else          irq_q <= irq_en_d & res_valid_d;
  end
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign job_valid_o = (state_q == S_ISSUE);
  assign job_data_o  = job_valid_o ? mem_q[rd_ptr_q] : 32'h0;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_wb_job_scheduler.sv
// Bench for wb_job_scheduler: directed table + corner sequences, then a
// randomized run against a queue-based transaction model.
module tb_wb_job_scheduler;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] CMD    = 32'h0;
  localparam logic [31:0] STATUS = 32'h4;
  localparam logic [31:0] RESULT = 32'h8;
  localparam logic [31:0] CTRL   = 32'hC;
`ifdef WB_JOB_SCHEDULER_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] wdat = '0, adr = '0;
  logic        ack;
  logic [31:0] rdat;
  logic        jv, jrdy = 1'b0, rv = 1'b0, busy, irq;
  logic [31:0] jd, rd_in = '0;

  int total = 0, bad = 0;

  wb_job_scheduler #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(wdat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .job_valid_o(jv), .job_data_o(jd), .job_ready_i(jrdy),
    .res_valid_i(rv), .res_data_i(rd_in), .busy_o(busy), .irq_o(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [67:0] act, input logic [67:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  // One bus access; called and returns at a negedge. Bounded to 8 cycles.
  task automatic bus(input bit w, input logic [31:0] off, input logic [31:0] d,
                     output logic [31:0] q, output bit got);
    stb = 1'b1; cyc = 1'b1; we = w; adr = BASE + off; wdat = d;
    got = 1'b0; q = '0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (ack) begin got = 1'b1; q = rdat; end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    logic [31:0] q; bit got;
    bus(1'b1, off, d, q, got);
    chk("write ack", 32'(got), 32'd1);
  endtask

  task automatic rdchk(input string nm, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] q; bit got;
    bus(1'b0, off, 32'h0, q, got);
    chk({nm, " ack"}, 32'(got), 32'd1);
    chk(nm, q, exp);
  endtask

  task automatic wait_jv(input string nm);
    bit got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (jv) begin got = 1'b1; break; end
      step();
    end
    chk(nm, 32'(got), 32'd1);
  endtask

  typedef struct {
    bit          w;
    logic [31:0] off;
    logic [31:0] d;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  // Reference model state (transaction level).
  logic [31:0] mq[$];
  bit          m_en, m_ie, m_ovf, m_rv, m_offer, m_wait, m_ack, m_irq;
  logic [31:0] m_res, m_dat;

  task automatic model_reset();
    mq.delete();
    m_en = 0; m_ie = 0; m_ovf = 0; m_rv = 0; m_offer = 0; m_wait = 0;
    m_ack = 0; m_irq = 0; m_res = '0; m_dat = '0;
  endtask

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_edge();
    bit          hit, acc, full, start, take, done;
    logic [1:0]  r;
    logic [31:0] rv_val;
    logic [3:0]  cnt;
    if (rst) begin model_reset(); return; end
    hit  = stb && cyc && (adr[31:4] == BASE[31:4]);
    acc  = hit && !m_ack;
    r    = adr[3:2];
    full = (mq.size() == DEPTH);
    cnt  = 4'(mq.size());
    case (r)
      2'd1:    rv_val = {24'h0, cnt, full, mq.size() == 0, m_rv, m_ovf};
      2'd2:    rv_val = m_res;
      2'd3:    rv_val = {30'h0, m_ie, m_en};
      default: rv_val = 32'h0;
    endcase
    start = !m_offer && !m_wait && m_en && mq.size() != 0;
    take  = m_offer && jrdy;
    done  = m_wait && rv;
    if (acc && we && r == 2'd0) begin
      if (full) m_ovf = 1'b1;
      else      mq.push_back(wdat);
    end
    if (acc && we && r == 2'd3) begin
      m_en = wdat[0];
      m_ie = IRQ ? wdat[1] : 1'b0;
      if (wdat[31]) m_ovf = 1'b0;
    end
    if (take) void'(mq.pop_front());
    if (done) begin m_res = rd_in; m_rv = 1'b1; end
    else if (acc && !we && r == 2'd2) m_rv = 1'b0;
    if (start)     m_offer = 1'b1;
    else if (take) begin m_offer = 1'b0; m_wait = 1'b1; end
    else if (done) m_wait = 1'b0;
    m_ack = acc;
    m_dat = (acc && !we) ? rv_val : 32'h0;
    m_irq = IRQ ? (m_ie && m_rv) : 1'b0;
  endtask

  initial begin
    vec_t        tbl[$];
    logic [31:0] q;
    bit          got, seen;

    // ---------------- reset state ----------------
    @(negedge clk);
    do_reset();
    chkv("reset outputs", {ack, rdat, jv, jd, busy, irq}, 68'h0);
    rdchk("reset status", STATUS, 32'h04);

    // ---------------- basic issue latency ----------------
    wr(CTRL, 32'h1);
    jrdy = 1'b1;
    idle(1);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + CMD; wdat = 32'hA5;
    step();
    chk("cmd ack after 1 cycle", 32'(ack), 32'd1);
    chk("no job yet", 32'(jv), 32'd0);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    step();
    chk("ack single cycle", 32'(ack), 32'd0);
    chk("job valid", 32'(jv), 32'd1);
    chk("job data", jd, 32'hA5);
    chk("busy in issue", 32'(busy), 32'd1);
    step();
    chk("wait state", {30'h0, jv, busy}, 32'b01);
    jrdy = 1'b0;

    // ---------------- result capture / irq ----------------
    wr(CTRL, 32'h3);
    rv = 1'b1; rd_in = 32'h1234; step(); rv = 1'b0;
    chk("irq after result", 32'(irq), 32'(IRQ));
    rdchk("status res_valid", STATUS, 32'h06);
    chk("irq held", 32'(irq), 32'(IRQ));
    rdchk("result read", RESULT, 32'h1234);
    chk("irq cleared by read", 32'(irq), 32'd0);
    rdchk("status after read", STATUS, 32'h04);
    rdchk("ctrl irq_en bit", CTRL, IRQ ? 32'h3 : 32'h1);

    // ---------------- capture coincident with RESULT read ----------------
    wr(CMD, 32'h77);
    idle(1);
    chk("second job data", jd, 32'h77);
    jrdy = 1'b1; step(); jrdy = 1'b0;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + RESULT;
    rv = 1'b1; rd_in = 32'h5555;
    step();
    rv = 1'b0; stb = 1'b0; cyc = 1'b0;
    chk("coincident read ack", 32'(ack), 32'd1);
    chk("coincident read old value", rdat, 32'h1234);
    rdchk("res_valid survives read", STATUS, 32'h06);
    rdchk("new result", RESULT, 32'h5555);

    // ---------------- table-driven register/overflow vectors ----------------
    do_reset();
    tbl.push_back('{0, STATUS, 0, 32'h04, "tbl status empty"});
    tbl.push_back('{0, CTRL,   0, 32'h00, "tbl ctrl reset"});
    tbl.push_back('{0, RESULT, 0, 32'h00, "tbl result reset"});
    for (int i = 0; i < 5; i++) tbl.push_back('{1, CMD, 32'(i), 0, "cmd"});
    tbl.push_back('{0, STATUS, 0, 32'h49, "tbl status full+ovf"});
    tbl.push_back('{0, CMD,    0, 32'h00, "tbl cmd reads zero"});
    tbl.push_back('{1, CTRL, 32'h8000_0000, 0, "clr ovf"});
    tbl.push_back('{0, STATUS, 0, 32'h48, "tbl status ovf cleared"});
    tbl.push_back('{1, CTRL, 32'h3, 0, "enable"});
    tbl.push_back('{0, CTRL,   0, IRQ ? 32'h3 : 32'h1, "tbl ctrl readback"});
    tbl.push_back('{0, STATUS, 0, 32'h48, "tbl status while offered"});
    tbl.push_back('{1, CTRL, 32'h0, 0, "disable"});
    foreach (tbl[i]) begin
      if (tbl[i].w) wr(tbl[i].off, tbl[i].d);
      else          rdchk(tbl[i].nm, tbl[i].off, tbl[i].exp);
    end
    chk("offer held after disable", 32'(jv), 32'd1);
    chk("held job data", jd, 32'h0);

    wr(CTRL, 32'h1);
    for (int i = 0; i < 4; i++) begin
      wait_jv("issue wait");
      chk("issue order", jd, 32'(i));
      jrdy = 1'b1; step(); jrdy = 1'b0;
      rv = 1'b1; rd_in = 32'h100 + 32'(i); step(); rv = 1'b0;
    end
    idle(2);
    chk("idle after drain", 32'(busy), 32'd0);
    rdchk("drained status", STATUS, 32'h06);
    rdchk("last result", RESULT, 32'h103);

    // ---------------- reset mid-job ----------------
    wr(CTRL, 32'h0);
    wr(CMD, 32'h10); wr(CMD, 32'h11); wr(CMD, 32'h12);
    wr(CTRL, 32'h1);
    wait_jv("mid-job issue");
    chk("mid-job head", jd, 32'h10);
    jrdy = 1'b1; step(); jrdy = 1'b0;
    chk("mid-job busy", 32'(busy), 32'd1);
    do_reset();
    chkv("outputs after reset", {ack, rdat, jv, jd, busy, irq}, 68'h0);
    rdchk("status after reset", STATUS, 32'h04);
    rv = 1'b1; rd_in = 32'hBEEF; step(); rv = 1'b0;
    rdchk("late result ignored", STATUS, 32'h04);
    rdchk("result still zero", RESULT, 32'h0);
    rdchk("ctrl after reset", CTRL, 32'h0);

    // ---------------- out-of-window access ----------------
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 32'h10; wdat = 32'hDEAD;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin step(); if (ack) seen = 1'b1; end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    chk("no ack outside window", 32'(seen), 32'd0);
    rdchk("no push outside window", STATUS, 32'h04);

    // ---------------- randomized vs model ----------------
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      chkv("random cycle", {ack, rdat, jv, jd, busy, irq},
           {m_ack, m_dat, m_offer, m_offer ? mq[0] : 32'h0, m_offer || m_wait, m_irq});
      rst   = ($urandom_range(0, 199) == 0);
      stb   = ($urandom_range(0, 2) != 0);
      cyc   = ($urandom_range(0, 7) != 0);
      we    = $urandom_range(0, 1) == 1;
      adr   = ($urandom_range(0, 15) == 0) ? BASE + 32'h10 + 32'($urandom_range(0, 3) << 2)
                                           : BASE + 32'($urandom_range(0, 3) << 2);
      wdat  = $urandom;
      if (adr[3:2] == 2'd3) begin
        wdat[0]  = ($urandom_range(0, 4) != 0);
        wdat[31] = ($urandom_range(0, 5) == 0);
      end
      sel   = 4'($urandom_range(0, 15));
      jrdy  = ($urandom_range(0, 2) == 0);
      rv    = ($urandom_range(0, 3) == 0);
      rd_in = $urandom;
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end
    rst = 1'b0; stb = 1'b0; cyc = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
